// File: rtl/adc_dual_sampler.sv
// Controller for the LTC6912 preamp + LTC1407A dual ADC sharing one SPI clock.
// Front-end pins and status outputs are flops decoded from the previous cycle's FSM state.
module adc_dual_sampler #(
   parameter int unsigned CLK_DIV       = 2,
   parameter int unsigned SAMPLE_PERIOD = 200,
   parameter logic [7:0]  INIT_GAIN     = 8'h11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cont,
   input  logic [3:0]         gain_a,
   input  logic [3:0]         gain_b,
   input  logic               gain_load,
   input  logic               AMP_DOUT,
   input  logic               AD_DOUT,
   output logic               SPI_MOSI,
   output logic               SPI_SCK,
   output logic               AMP_CS,
   output logic               AD_CONV,
   output logic               AMP_SHDN,
   output logic signed [13:0] sample_a,
   output logic signed [13:0] sample_b,
   output logic               sample_valid,
   output logic               clip,
   output logic [7:0]         gain_rb,
   output logic               busy
);

   localparam int unsigned    PH_W    = $clog2(2 * CLK_DIV);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

   typedef enum logic [2:0] {S_GAIN, S_GAP, S_CONV, S_READ, S_DONE, S_WAIT, S_IDLE} state_t;

   state_t           state_q, state_d;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [5:0]       slot_q, slot_d;
   logic [15:0]      per_q, per_d;
   logic             start_pend_q, start_pend_d;
   logic             gain_pend_q, gain_pend_d;
   logic [7:0]       gain_word_q, gain_word_d;
   logic [7:0]       tx_q, tx_d;
   logic [7:0]       amp_rx_q, amp_rx_d;
   logic [13:0]      a_rx_q, a_rx_d, b_rx_q, b_rx_d;
   logic             mosi_q, mosi_d, sck_q, sck_d, cs_q, cs_d, conv_q, conv_d;
   logic [13:0]      sample_a_q, sample_a_d, sample_b_q, sample_b_d;
   logic             valid_q, valid_d, clip_q, clip_d, busy_q, busy_d;
   logic [7:0]       gain_rb_q, gain_rb_d;

   logic ph_end, shift_now, entering, period_done;

   assign ph_end      = (ph_q == PH_LAST);
   assign shift_now   = (ph_q == PH_HIGH);
   assign period_done = (32'(per_q) + 32'd2 >= SAMPLE_PERIOD);

   function automatic logic is_rail(input logic [13:0] v);
      return (v == 14'h1FFF) || (v == 14'h2000);
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_GAIN:  if (ph_end && slot_q == 6'd7) state_d = S_GAP;
         S_GAP:   if (ph_end) state_d = S_IDLE;
         S_IDLE:  if (gain_load || gain_pend_q) state_d = S_GAIN;
                  else if (start || start_pend_q || cont) state_d = S_CONV;
         S_CONV:  if (ph_end) state_d = S_READ;
         S_READ:  if (ph_end && slot_q == 6'd33) state_d = S_DONE;
         S_DONE:  state_d = (cont && !period_done) ? S_WAIT : S_IDLE;
         S_WAIT:  if (!cont || period_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      entering     = (state_d != state_q);
      ph_d         = (entering || ph_end) ? '0 : ph_q + PH_W'(1);
      slot_d       = entering ? 6'd0 : (ph_end ? slot_q + 6'd1 : slot_q);
      per_d        = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
      start_pend_d = start_pend_q | start;
      gain_pend_d  = gain_pend_q | gain_load;
      gain_word_d  = gain_load ? {gain_b, gain_a} : gain_word_q;
      if (entering && state_d == S_CONV) begin
         per_d        = '0;
         start_pend_d = 1'b0;
      end
      if (entering && state_d == S_GAIN) gain_pend_d = 1'b0;

      tx_d = tx_q;
      if (entering && state_d == S_GAIN) tx_d = gain_word_d;
      else if (state_q == S_GAIN && ph_end) tx_d = {tx_q[6:0], 1'b0};

      // ADC frame: slots 2..15 carry channel A, 18..31 channel B, both MSB first.
      amp_rx_d = amp_rx_q;
      a_rx_d   = a_rx_q;
      b_rx_d   = b_rx_q;
      if (state_q == S_GAIN && shift_now) amp_rx_d = {amp_rx_q[6:0], AMP_DOUT};
      if (state_q == S_READ && shift_now) begin
         if (slot_q >= 6'd2 && slot_q <= 6'd15)  a_rx_d = {a_rx_q[12:0], AD_DOUT};
         if (slot_q >= 6'd18 && slot_q <= 6'd31) b_rx_d = {b_rx_q[12:0], AD_DOUT};
      end
   end

   always_comb begin
      mosi_d     = (state_q == S_GAIN) && tx_q[7];
      sck_d      = (state_q == S_GAIN || state_q == S_READ) && (ph_q >= PH_HIGH);
      cs_d       = (state_q != S_GAIN);
      conv_d     = (state_q == S_CONV);
      busy_d     = (state_q != S_IDLE);
      valid_d    = (state_q == S_DONE);
      sample_a_d = valid_d ? a_rx_q : sample_a_q;
      sample_b_d = valid_d ? b_rx_q : sample_b_q;
      clip_d     = valid_d ? (is_rail(a_rx_q) || is_rail(b_rx_q)) : clip_q;
      gain_rb_d  = (state_q == S_GAIN && slot_q == 6'd7 && ph_end) ? amp_rx_d : gain_rb_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_GAIN;
         ph_q         <= '0;
         slot_q       <= '0;
         per_q        <= '0;
         start_pend_q <= 1'b0;
         gain_pend_q  <= 1'b0;
         gain_word_q  <= INIT_GAIN;
         tx_q         <= INIT_GAIN;
         amp_rx_q     <= '0;
         a_rx_q       <= '0;
         b_rx_q       <= '0;
         mosi_q       <= 1'b0;
         sck_q        <= 1'b0;
         cs_q         <= 1'b1;
         conv_q       <= 1'b0;
         sample_a_q   <= '0;
         sample_b_q   <= '0;
         valid_q      <= 1'b0;
         clip_q       <= 1'b0;
         busy_q       <= 1'b0;
         gain_rb_q    <= '0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         slot_q       <= slot_d;
         per_q        <= per_d;
         start_pend_q <= start_pend_d;
         gain_pend_q  <= gain_pend_d;
         gain_word_q  <= gain_word_d;
         tx_q         <= tx_d;
         amp_rx_q     <= amp_rx_d;
         a_rx_q       <= a_rx_d;
         b_rx_q       <= b_rx_d;
         mosi_q       <= mosi_d;
         sck_q        <= sck_d;
         cs_q         <= cs_d;
         conv_q       <= conv_d;
         sample_a_q   <= sample_a_d;
         sample_b_q   <= sample_b_d;
         valid_q      <= valid_d;
         clip_q       <= clip_d;
         busy_q       <= busy_d;
         gain_rb_q    <= gain_rb_d;
      end
   end

   assign SPI_MOSI     = mosi_q;
   assign SPI_SCK      = sck_q;
   assign AMP_CS       = cs_q;
   assign AD_CONV      = conv_q;
   assign AMP_SHDN     = 1'b0;
   assign sample_a     = sample_a_q;
   assign sample_b     = sample_b_q;
   assign sample_valid = valid_q;
   assign clip         = clip_q;
   assign gain_rb      = gain_rb_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_adc_dual_sampler.sv
// Bench for adc_dual_sampler: preamp/ADC pin models, sample scoreboard, timing checks.
// A second instance with a short SAMPLE_PERIOD checks the minimum continuous spacing.
module tb_adc_dual_sampler;

   typedef struct {
      logic [13:0] a;
      logic [13:0] b;
      logic        clip;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, cont = 1'b0, gain_load = 1'b0;
   logic [3:0]  gain_a = 4'd0, gain_b = 4'd0;
   logic        amp_dout, ad_dout;
   logic        spi_mosi, spi_sck, amp_cs, ad_conv, amp_shdn;
   logic [13:0] sample_a, sample_b;
   logic        sample_valid, clip, busy;
   logic [7:0]  gain_rb;

   logic        cont2 = 1'b0, zero_in = 1'b0;
   logic [3:0]  zero4 = 4'd0;
   logic        d2_mosi, d2_sck, d2_cs, d2_conv, d2_shdn, d2_valid, d2_clip, d2_busy;
   logic [13:0] d2_a, d2_b;
   logic [7:0]  d2_rb;

   int n_total = 0;
   int n_bad   = 0;
   int n_valid = 0;
   int cyc     = 0;

   exp_t exp_q[$];
   int   rise_q[$];
   int   rise2_q[$];

   logic [7:0]  amp_sr = 8'hFF;
   logic [13:0] adc_a = 14'd0, adc_b = 14'd0, fr_a = 14'd0, fr_b = 14'd0;
   int          idx = 0;

   adc_dual_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .INIT_GAIN(8'h11)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .gain_a(gain_a), .gain_b(gain_b),
      .gain_load(gain_load), .AMP_DOUT(amp_dout), .AD_DOUT(ad_dout), .SPI_MOSI(spi_mosi),
      .SPI_SCK(spi_sck), .AMP_CS(amp_cs), .AD_CONV(ad_conv), .AMP_SHDN(amp_shdn),
      .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid), .clip(clip),
      .gain_rb(gain_rb), .busy(busy)
   );

   adc_dual_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(50), .INIT_GAIN(8'h11)) dut_fast (
      .clk(clk), .rst(rst), .start(zero_in), .cont(cont2), .gain_a(zero4), .gain_b(zero4),
      .gain_load(zero_in), .AMP_DOUT(zero_in), .AD_DOUT(zero_in), .SPI_MOSI(d2_mosi),
      .SPI_SCK(d2_sck), .AMP_CS(d2_cs), .AD_CONV(d2_conv), .AMP_SHDN(d2_shdn),
      .sample_a(d2_a), .sample_b(d2_b), .sample_valid(d2_valid), .clip(d2_clip),
      .gain_rb(d2_rb), .busy(d2_busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cyc <= cyc + 1;

   function automatic logic rail(input logic [13:0] v);
      return (v == 14'h1FFF) || (v == 14'h2000);
   endfunction

   function automatic logic adc_bit(input int i, input logic [13:0] a, input logic [13:0] b);
      if (i >= 2 && i <= 15)  return a[15 - i];
      if (i >= 18 && i <= 31) return b[31 - i];
      return 1'b1;
   endfunction

   // Preamp: shifts MOSI in on SCK rise, presents the previous word MSB first.
   assign amp_dout = amp_sr[7];
   always @(posedge spi_sck) if (!amp_cs) amp_sr <= {amp_sr[6:0], spi_mosi};

   // ADC: latch the analog values at AD_CONV rise, step one bit per SCK fall.
   always @(posedge ad_conv or negedge spi_sck) begin
      if (ad_conv) begin
         fr_a <= adc_a;
         fr_b <= adc_b;
         idx  <= 0;
         exp_q.push_back('{adc_a, adc_b, rail(adc_a) || rail(adc_b)});
         rise_q.push_back(cyc);
      end else if (amp_cs) begin
         idx <= idx + 1;
      end
   end
   assign ad_dout = adc_bit(idx, fr_a, fr_b);

   always @(posedge d2_conv) rise2_q.push_back(cyc);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && sample_valid) begin
         n_valid++;
         check("exp_available", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sample_a", {18'd0, sample_a}, {18'd0, e.a});
            check("sample_b", {18'd0, sample_b}, {18'd0, e.b});
            check("clip", {31'd0, clip}, {31'd0, e.clip});
         end
      end
   end

   task automatic wait_idle(input string name);
      int k = 0;
      do begin
         @(posedge clk); #1; k++;
      end while (busy && k < 2000);
      check(name, {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_rises(input int n, input string name);
      int k = 0;
      while (rise_q.size() < n && k < 1000) begin
         @(posedge clk); k++;
      end
      check(name, rise_q.size(), n);
   endtask

   task automatic single(input logic [13:0] a, input logic [13:0] b);
      adc_a = a;
      adc_b = b;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle("single_idle");
   endtask

   task automatic gain_frame(input string name);
      int cs_low = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (!amp_cs) cs_low++;
      end
      check(name, cs_low, 32);
   endtask

   initial begin
      int n, conv_first, conv_len, busy_hi, k, v0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_amp_cs", {31'd0, amp_cs}, 32'd1);
      check("rst_sck", {31'd0, spi_sck}, 32'd0);
      check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
      check("rst_conv", {31'd0, ad_conv}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, sample_valid}, 32'd0);
      check("rst_gain_rb", {24'd0, gain_rb}, 32'd0);

      // Power-up gain frame.
      @(negedge clk) rst = 1'b0;
      n = 0; busy_hi = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (!amp_cs) n++;
         if (busy) busy_hi++;
      end
      check("init_cs_low_cycles", n, 32);
      check("init_busy_cycles", busy_hi, 36);
      check("init_word_sent", {24'd0, amp_sr}, 32'h11);
      check("init_gain_rb", {24'd0, gain_rb}, 32'hFF);
      check("amp_shdn", {31'd0, amp_shdn}, 32'd0);

      // Single shot with latency measurement.
      adc_a = 14'h1234;
      adc_b = 14'h3ABC;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0; conv_first = -1; conv_len = 0;
      while (!sample_valid && n < 400) begin
         @(posedge clk); n++; #1;
         if (ad_conv) begin
            conv_len++;
            if (conv_first < 0) conv_first = n;
         end
      end
      check("ss_valid_latency", n, 141);
      check("ss_conv_first", conv_first, 1);
      check("ss_conv_len", conv_len, 4);
      wait_idle("ss_idle");

      // Clip boundaries.
      single(14'h1FFF, 14'h0100);
      check("clip_held", {31'd0, clip}, 32'd1);
      single(14'h0000, 14'h0000);
      single(14'h0005, 14'h2000);
      single(14'h1FFE, 14'h2001);

      // Continuous spacing: SAMPLE_PERIOD=200 and 50 (floored at 142).
      adc_a = 14'h0AAA;
      adc_b = 14'h1555;
      rise_q.delete();
      rise2_q.delete();
      @(negedge clk) begin cont = 1'b1; cont2 = 1'b1; end
      k = 0;
      while (rise_q.size() < 3 && k < 1000) begin
         @(negedge clk); k++;
         if (rise2_q.size() >= 3) cont2 = 1'b0;
      end
      cont = 1'b0;
      cont2 = 1'b0;
      check("cont_rises", rise_q.size(), 3);
      check("fast_rises", 32'(rise2_q.size() >= 3), 32'd1);
      if (rise_q.size() >= 3) begin
         check("cont_period_1", rise_q[1] - rise_q[0], 200);
         check("cont_period_2", rise_q[2] - rise_q[1], 200);
      end
      if (rise2_q.size() >= 3) begin
         check("fast_period_1", rise2_q[1] - rise2_q[0], 142);
         check("fast_period_2", rise2_q[2] - rise2_q[1], 142);
      end
      wait_idle("cont_stop_idle");

      // Gain load during READ in continuous mode.
      adc_a = 14'h0123;
      adc_b = 14'h2FED;
      rise_q.delete();
      @(negedge clk) cont = 1'b1;
      wait_rises(1, "gl_first_rise");
      repeat (60) @(posedge clk);
      @(negedge clk) begin gain_a = 4'd3; gain_b = 4'd5; gain_load = 1'b1; end
      @(negedge clk) gain_load = 1'b0;
      wait_rises(2, "gl_second_rise");
      if (rise_q.size() >= 2) check("gl_delayed_period", rise_q[1] - rise_q[0], 237);
      check("gl_word_sent", {24'd0, amp_sr}, 32'h53);
      check("gl_gain_rb", {24'd0, gain_rb}, 32'h11);
      wait_rises(3, "gl_third_rise");
      if (rise_q.size() >= 3) check("gl_period_after", rise_q[2] - rise_q[1], 200);
      @(negedge clk) cont = 1'b0;
      wait_idle("gl_idle");

      // Reset in the middle of READ.
      adc_a = 14'h0777;
      adc_b = 14'h0888;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      k = 0;
      while (!spi_sck && k < 10) begin
         @(posedge clk); #1; k++;
      end
      check("rr_sck_high_before", {31'd0, spi_sck}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rr_sck", {31'd0, spi_sck}, 32'd0);
      check("rr_amp_cs", {31'd0, amp_cs}, 32'd1);
      check("rr_conv", {31'd0, ad_conv}, 32'd0);
      check("rr_sample_a", {18'd0, sample_a}, 32'd0);
      check("rr_sample_b", {18'd0, sample_b}, 32'd0);
      exp_q.delete();
      v0 = n_valid;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      gain_frame("rr_cs_low_cycles");
      check("rr_init_resent", {24'd0, amp_sr}, 32'h11);
      check("rr_gain_rb", {24'd0, gain_rb}, 32'h53);
      repeat (150) @(posedge clk);
      #1;
      check("rr_no_valid", n_valid, v0);
      check("rr_idle", {31'd0, busy}, 32'd0);

      check("exp_queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
